// File: rtl/arm_mem_responder.sv
// ---------------------------------------------------------------------------
// arm_mem_responder : wait-stated word memory behind valid/ready req/rsp
// channels. Optional ARM_MEM_ROTATE_EN gives ARMv4 rotated unaligned loads.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arm_mem_responder #(
   parameter int DEPTH       = 4096,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         AW        = $clog2(DEPTH);
   localparam logic [3:0] c_wait_ld = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic          access;
   logic          mem_wr;
   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_be;
   logic [AW-1:0] acc_idx;
   logic          acc_unaligned;
   logic          acc_oor;
   logic          acc_err;
   logic [31:0]   mem_word;
   logic [31:0]   rot_word;

   logic [31:0] mem [DEPTH];

   // With zero wait states the access happens on the accept edge, so the
   // operands come straight from the request pins; otherwise from the latch.
   always_comb begin
      if (state_q == IDLE) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
   end

   assign acc_idx       = acc_addr[AW+1:2];
   assign acc_unaligned = (acc_addr[1:0] != 2'b00);
   assign mem_word      = mem[acc_idx];

   generate
      if (AW + 2 < 32) begin : g_range
         assign acc_oor = |acc_addr[31:AW+2];
      end else begin : g_norange
         assign acc_oor = 1'b0;
      end
   endgenerate

`ifdef ARM_MEM_ROTATE_EN
   logic [63:0] rot_dbl;
   assign rot_dbl  = {mem_word, mem_word} >> {acc_addr[1:0], 3'b000};
   assign rot_word = rot_dbl[31:0];
   assign acc_err  = acc_oor | (acc_we & acc_unaligned);
`else
   assign rot_word = mem_word;
   assign acc_err  = acc_oor | acc_unaligned;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      access  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               if (WAIT_STATES == 0) begin
                  access  = 1'b1;
                  state_d = RESP;
               end else begin
                  cnt_d   = c_wait_ld;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (access) begin
         err_d   = acc_err;
         rdata_d = (acc_err || acc_we) ? 32'd0 : rot_word;
      end
   end

   // Gating with reset_n keeps an access abandoned by reset from committing.
   assign mem_wr = access & acc_we & ~acc_err & reset_n;

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE) && reset_n;
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: doc/arm_mem_responder.md
Name: arm_mem_responder

Overview:
Memory-side responder for the ARM32 core's load/store and fetch port. It accepts one word-addressed request at a time over a valid/ready request channel and holds it for a programmable number of wait states. It then returns read data or a write acknowledge over a valid/ready response channel. It replaces direct array peeking of RAM by the core and sits between the processor and the on-chip word memory.

Parameters:
DEPTH, 4096, number of 32-bit words in the memory array; power of two.
WAIT_STATES, 2, extra cycles between request accept and response valid (0..15).

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept request
req_we  input  1  1 = write (STR), 0 = read (LDR/fetch)
req_addr  input  32  byte address
req_wdata  input  32  write data
req_be  input  4  byte enables, bit i = byte lane i (little-endian)
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  32  read data; 0 for writes and errors
rsp_err  output  1  access fault

Behaviour:
- Interface: clock clk, reset reset_n, synchronous, active-low.
- Reset: state IDLE, req_ready=0 during reset then 1 in IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not reset. Reset asserted mid-transaction abandons it: no write is committed if the BUSY→RESP transition has not occurred.
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/be.
  - If WAIT_STATES==0, go to RESP.
  - Otherwise load counter=WAIT_STATES-1 and go to BUSY.
- BUSY: req_ready=0. Counter decrements each cycle. At counter==0, perform the access and go to RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE (req_ready=1 next cycle). A held rsp_ready=0 stalls indefinitely.
- Latency: request accepted in cycle N gives rsp_valid high from cycle N+1+WAIT_STATES. Throughput is at most one transaction per 2+WAIT_STATES cycles.
- Index: word index = req_addr[log2(DEPTH)+1:2].
- Error: rsp_err=1 when req_addr[1:0]!=0 or req_addr[31:log2(DEPTH)+2]!=0. On error: no memory write, rsp_rdata=0.
- Write: for each i with req_be[i]=1, mem[idx][8i+7:8i] <= wdata byte i; other bytes unchanged. be=0 is a legal no-op write acknowledged with rsp_err=0. rsp_rdata=0.
- Read: rsp_rdata=mem[idx], sampled on the cycle the access is performed. A write followed by a read to the same word returns the new data. req_be is ignored on reads.
- req_* inputs are don't-care except in IDLE. Changes to req_* after accept have no effect.

Optional Feature:
Macro ARM_MEM_ROTATE_EN.
- Defined: unaligned reads are legal (ARMv4 LDR semantics). rsp_rdata = mem[idx] rotated right by 8*req_addr[1:0], and rsp_err is raised only for out-of-range addresses. Unaligned writes still fault.
- Undefined: any unaligned access faults as above.

Test Plan:
- Reset, WAIT_STATES=2: write addr 0x10, wdata 0xDEADBEEF, be=4'hF; accept at cycle N -> rsp_valid at N+3, err=0, rdata=0. Read 0x10 -> rdata 0xDEADBEEF.
- Byte lanes: mem[4]=0x11223344; write addr 0x10, wdata 0xAABBCCDD, be=4'b0101 -> read 0x10 returns 0x11BB33DD.
- Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0 throughout. rsp_ready=1 -> req_ready=1 next cycle.
- Faults: read 0x12 -> err=1, rdata=0. Write 0x00004000 (DEPTH=4096) -> err=1, and a subsequent read 0x0 is unchanged.
- Reset mid-BUSY after a write to 0x20 of 0x12345678 (previously 0) -> after reset, read 0x20 returns 0; outputs at reset values during reset.
- WAIT_STATES=0 back-to-back: requests held valid -> accept every 2 cycles. With ARM_MEM_ROTATE_EN, mem[0]=0x11223344 and read 0x1 -> rdata 0x44112233, err=0.
